// File: rtl/lane_block_pool_pkg.sv
// Shared game constants and small types for the per-lane falling-block pool.
package lane_block_pool_pkg;

    // Playfield geometry shared with the rest of the game
    localparam int unsigned LBP_H_W      = 10;
    localparam int unsigned LBP_SPAWN_Y  = 120;
    localparam int unsigned LBP_BOTTOM_Y = 720;
    localparam int unsigned LBP_HIT_LO   = 600;
    localparam int unsigned LBP_HIT_HI   = 680;

    // Outcome of a key press in one cycle
    typedef enum logic [1:0] {
        HIT_NONE = 2'd0,
        HIT_OK   = 2'd1,
        HIT_BAD  = 2'd2
    } hit_res_e;

endpackage

// File: rtl/lbp_hit_select.sv
// Picks the live block deepest inside the hit window; ties resolve to the
// lowest slot index. Purely combinational.
module lbp_hit_select
    import lane_block_pool_pkg::*;
#(
    parameter int unsigned SLOTS  = 4,
    parameter int unsigned H_W    = LBP_H_W,
    parameter int unsigned HIT_LO = LBP_HIT_LO,
    parameter int unsigned HIT_HI = LBP_HIT_HI
)(
    input  logic [SLOTS*H_W-1:0] pos,
    input  logic [SLOTS-1:0]     valid,
    output logic [SLOTS-1:0]     sel,
    output logic                 found
);

    localparam logic [H_W-1:0] LO_H = H_W'(HIT_LO);
    localparam logic [H_W-1:0] HI_H = H_W'(HIT_HI);

    logic [H_W-1:0] cand_h_s;
    logic [H_W-1:0] best_h_s;
    logic [3:0]     best_idx_s;

    // Scan slots upward; strict greater-than keeps the lower index on a tie
    always_comb begin
        found      = 1'b0;
        best_h_s   = '0;
        best_idx_s = 4'd0;
        cand_h_s   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            cand_h_s = pos[i*H_W +: H_W];
            if (valid[i] && (cand_h_s >= LO_H) && (cand_h_s <= HI_H) &&
                (!found || (cand_h_s > best_h_s))) begin
                found      = 1'b1;
                best_h_s   = cand_h_s;
                best_idx_s = 4'(i);
            end else begin
                found      = found;
                best_h_s   = best_h_s;
                best_idx_s = best_idx_s;
            end
        end
    end

    // Expand the winning index into a one-hot select
    always_comb begin
        sel = '0;
        for (int i = 0; i < SLOTS; i++) begin
            sel[i] = found && (best_idx_s == 4'(i));
        end
    end

endmodule

// File: rtl/lane_block_pool.sv
// One lane of falling note blocks: spawns on masked beats, moves every tick,
// resolves key presses against the hit window and reports misses.
module lane_block_pool
    import lane_block_pool_pkg::*;
#(
    parameter int unsigned SLOTS    = 4,
    parameter int unsigned H_W      = LBP_H_W,
    parameter int unsigned BEAT_W   = 7,
    parameter int unsigned SPAWN_Y  = LBP_SPAWN_Y,
    parameter int unsigned BOTTOM_Y = LBP_BOTTOM_Y,
    parameter int unsigned STEP     = 1,
    parameter int unsigned HIT_LO   = LBP_HIT_LO,
    parameter int unsigned HIT_HI   = LBP_HIT_HI,
    parameter logic [(2**BEAT_W)-1:0] SPAWN_MASK = '0
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    input  logic                 stop_or_endgame,
    input  logic [BEAT_W-1:0]    beat_cnt,
    input  logic                 hit_req,
    output logic [SLOTS*H_W-1:0] block_h,
    output logic [SLOTS-1:0]     block_valid,
    output logic                 hit_ok,
    output logic                 hit_bad,
    output logic                 miss,
    output logic                 overflow
);

    // One extra bit on motion arithmetic so h+STEP can never wrap
    localparam logic [H_W:0]   STEP_X   = (H_W+1)'(STEP);
    localparam logic [H_W:0]   BOTTOM_X = (H_W+1)'(BOTTOM_Y);
    localparam logic [H_W-1:0] BOTTOM_H = H_W'(BOTTOM_Y);
    localparam logic [H_W-1:0] SPAWN_H  = H_W'(SPAWN_Y);

    logic [SLOTS*H_W-1:0] h_r;
    logic [SLOTS-1:0]     valid_r;
    logic [BEAT_W-1:0]    pre_beat_r;
    logic                 hit_ok_r;
    logic                 hit_bad_r;
    logic                 miss_r;
    logic                 overflow_r;

    logic                 beat_new_s;
    logic                 spawn_s;
    logic                 hit_go_s;
    logic [SLOTS-1:0]     hit_sel_s;
    logic                 hit_found_s;
    hit_res_e             hit_res_s;
    logic [SLOTS-1:0]     alloc_s;
    logic                 free_seen_s;
    logic                 any_free_s;
    logic [SLOTS*H_W-1:0] h_nxt_s;
    logic [SLOTS-1:0]     valid_nxt_s;
    logic [SLOTS-1:0]     expire_s;
    logic [H_W:0]         adv_s;

    lbp_hit_select #(
        .SLOTS  (SLOTS),
        .H_W    (H_W),
        .HIT_LO (HIT_LO),
        .HIT_HI (HIT_HI)
    ) u_hit_select (
        .pos   (h_r),
        .valid (valid_r),
        .sel   (hit_sel_s),
        .found (hit_found_s)
    );

    // Beat edge detect; a wrap to a smaller beat number is not a new beat
    always_comb begin
        beat_new_s = (beat_cnt > pre_beat_r);
        spawn_s    = beat_new_s && SPAWN_MASK[beat_cnt] && !stop_or_endgame;
        hit_go_s   = hit_req && !stop_or_endgame;
        any_free_s = |(~valid_r);
    end

    // Lowest slot that was already free when the cycle began
    always_comb begin
        alloc_s     = '0;
        free_seen_s = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!valid_r[i] && !free_seen_s) begin
                alloc_s[i]  = 1'b1;
                free_seen_s = 1'b1;
            end else begin
                alloc_s[i]  = 1'b0;
                free_seen_s = free_seen_s;
            end
        end
    end

    // Per-slot next state: freeze, hit clear, advance/expire, or spawn
    always_comb begin
        h_nxt_s     = h_r;
        valid_nxt_s = valid_r;
        expire_s    = '0;
        adv_s       = '0;
        for (int i = 0; i < SLOTS; i++) begin
            adv_s = {1'b0, h_r[i*H_W +: H_W]} + STEP_X;
            if (stop_or_endgame) begin
                h_nxt_s[i*H_W +: H_W] = h_r[i*H_W +: H_W];
                valid_nxt_s[i]        = valid_r[i];
            end else if (hit_go_s && hit_sel_s[i]) begin
                h_nxt_s[i*H_W +: H_W] = BOTTOM_H;
                valid_nxt_s[i]        = 1'b0;
            end else if (valid_r[i]) begin
                if (adv_s >= BOTTOM_X) begin
                    h_nxt_s[i*H_W +: H_W] = BOTTOM_H;
                    valid_nxt_s[i]        = 1'b0;
                    expire_s[i]           = 1'b1;
                end else begin
                    h_nxt_s[i*H_W +: H_W] = adv_s[H_W-1:0];
                    valid_nxt_s[i]        = 1'b1;
                end
            end else if (spawn_s && alloc_s[i]) begin
                h_nxt_s[i*H_W +: H_W] = SPAWN_H;
                valid_nxt_s[i]        = 1'b1;
            end else begin
                h_nxt_s[i*H_W +: H_W] = BOTTOM_H;
                valid_nxt_s[i]        = 1'b0;
            end
        end
    end

    // Classify this cycle's key press
    always_comb begin
        hit_res_s = HIT_NONE;
        if (hit_go_s) begin
            if (hit_found_s) begin
                hit_res_s = HIT_OK;
            end else begin
                hit_res_s = HIT_BAD;
            end
        end else begin
            hit_res_s = HIT_NONE;
        end
    end

    // State and event registers; restart clears the lane like a reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_r        <= {SLOTS{BOTTOM_H}};
            valid_r    <= '0;
            pre_beat_r <= '0;
            hit_ok_r   <= 1'b0;
            hit_bad_r  <= 1'b0;
            miss_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else if (restart) begin
            h_r        <= {SLOTS{BOTTOM_H}};
            valid_r    <= '0;
            pre_beat_r <= '0;
            hit_ok_r   <= 1'b0;
            hit_bad_r  <= 1'b0;
            miss_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            h_r        <= h_nxt_s;
            valid_r    <= valid_nxt_s;
            pre_beat_r <= beat_cnt;
            miss_r     <= |expire_s;
            overflow_r <= overflow_r | (spawn_s && !any_free_s);
            case (hit_res_s)
                HIT_OK: begin
                    hit_ok_r  <= 1'b1;
                    hit_bad_r <= 1'b0;
                end
                HIT_BAD: begin
                    hit_ok_r  <= 1'b0;
                    hit_bad_r <= 1'b1;
                end
                default: begin
                    hit_ok_r  <= 1'b0;
                    hit_bad_r <= 1'b0;
                end
            endcase
        end
    end

    assign block_h     = h_r;
    assign block_valid = valid_r;
    assign hit_ok      = hit_ok_r;
    assign hit_bad     = hit_bad_r;
    assign miss        = miss_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_lane_block_pool.sv
// Scenario bench for lane_block_pool: expected lane states are queued before
// each clock edge and compared after it.
module tb_lane_block_pool;

    localparam int B = 720;
    localparam int S = 120;
    localparam logic [127:0] MASK = 128'h0000_0000_0000_0000_0000_0000_0000_FF00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        stop_or_endgame;
    logic [6:0]  beat_cnt;
    logic        hit_req;
    logic [39:0] block_h;
    logic [3:0]  block_valid;
    logic        hit_ok;
    logic        hit_bad;
    logic        miss;
    logic        overflow;

    logic [47:0] obs;
    string       tag_q[$];
    logic [47:0] val_q[$];
    string       et;
    logic [47:0] ev_v;
    int          vectors = 0;
    int          miscompares = 0;

    assign obs = {block_h, block_valid, hit_ok, hit_bad, miss, overflow};

    lane_block_pool #(.SPAWN_MASK(MASK)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .restart         (restart),
        .stop_or_endgame (stop_or_endgame),
        .beat_cnt        (beat_cnt),
        .hit_req         (hit_req),
        .block_h         (block_h),
        .block_valid     (block_valid),
        .hit_ok          (hit_ok),
        .hit_bad         (hit_bad),
        .miss            (miss),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // Expected lane image; fl = {hit_ok, hit_bad, miss, overflow}
    function automatic logic [47:0] ev(int h3, int h2, int h1, int h0, logic [3:0] v, logic [3:0] fl);
        return {10'(h3), 10'(h2), 10'(h1), 10'(h0), v, fl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(int n);
        repeat (n) tick();
    endtask

    task automatic push(string t, logic [47:0] v);
        tag_q.push_back(t);
        val_q.push_back(v);
    endtask

    task automatic do_restart();
        restart = 1'b1; beat_cnt = 7'd0; hit_req = 1'b0; stop_or_endgame = 1'b0;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; restart = 1'b0; stop_or_endgame = 1'b0; beat_cnt = 7'd0; hit_req = 1'b0;
        push("reset_hold", ev(B, B, B, B, 4'b0000, 4'b0000));
        tick_n(2);
        et = tag_q.pop_front(); ev_v = val_q.pop_front(); vectors++;
        if (obs !== ev_v) begin miscompares++; $display("FAIL %s: got h=%h v=%b flags=%b, want h=%h v=%b flags=%b", et, obs[47:8], obs[7:4], obs[3:0], ev_v[47:8], ev_v[7:4], ev_v[3:0]); end
        rst_n = 1'b1;
        push("reset_release", ev(B, B, B, B, 4'b0000, 4'b0000));
        tick();
        et = tag_q.pop_front(); ev_v = val_q.pop_front(); vectors++;
        if (obs !== ev_v) begin miscompares++; $display("FAIL %s: got h=%h v=%b flags=%b, want h=%h v=%b flags=%b", et, obs[47:8], obs[7:4], obs[3:0], ev_v[47:8], ev_v[7:4], ev_v[3:0]); end
    endtask

    task automatic test_spawn();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin beat_cnt = 7'd7; push("beat7_no_spawn", ev(B, B, B, B, 4'b0000, 4'b0000)); tick(); end
            else if (k == 1) begin beat_cnt = 7'd8; push("spawn_slot0", ev(B, B, B, S, 4'b0001, 4'b0000)); tick(); end
            else begin tick_n(479); push("fall_480", ev(B, B, B, 600, 4'b0001, 4'b0000)); tick(); end
            et = tag_q.pop_front(); ev_v = val_q.pop_front(); vectors++;
            if (obs !== ev_v) begin miscompares++; $display("FAIL %s: got h=%h v=%b flags=%b, want h=%h v=%b flags=%b", et, obs[47:8], obs[7:4], obs[3:0], ev_v[47:8], ev_v[7:4], ev_v[3:0]); end
        end
    endtask

    task automatic test_hit();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin tick_n(40); hit_req = 1'b1; push("hit_ok_640", ev(B, B, B, B, 4'b0000, 4'b1000)); end
            else if (k == 1) begin push("hit_ok_one_cycle", ev(B, B, B, B, 4'b0000, 4'b0000)); end
            else begin hit_req = 1'b1; push("hit_bad_empty", ev(B, B, B, B, 4'b0000, 4'b0100)); end
            tick();
            hit_req = 1'b0;
            et = tag_q.pop_front(); ev_v = val_q.pop_front(); vectors++;
            if (obs !== ev_v) begin miscompares++; $display("FAIL %s: got h=%h v=%b flags=%b, want h=%h v=%b flags=%b", et, obs[47:8], obs[7:4], obs[3:0], ev_v[47:8], ev_v[7:4], ev_v[3:0]); end
        end
    endtask

    task automatic test_select_and_miss();
        do_restart();
        beat_cnt = 7'd8; tick();          // A = 120
        tick_n(79);                       // A = 199
        beat_cnt = 7'd9; tick();          // A = 200, B = 120
        tick_n(399);                      // A = 599, B = 519
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin hit_req = 1'b1; push("hit_below_window", ev(B, B, 520, 600, 4'b0011, 4'b0100)); end
            else if (k == 1) begin tick_n(81); hit_req = 1'b1; push("hit_skips_above_hi", ev(B, B, B, 682, 4'b0001, 4'b1000)); end
            else if (k == 2) begin tick_n(37); beat_cnt = 7'd10; push("miss_spawn_slot1", ev(B, B, S, B, 4'b0010, 4'b0010)); end
            else begin push("miss_one_cycle", ev(B, B, 121, B, 4'b0010, 4'b0000)); end
            tick();
            hit_req = 1'b0;
            et = tag_q.pop_front(); ev_v = val_q.pop_front(); vectors++;
            if (obs !== ev_v) begin miscompares++; $display("FAIL %s: got h=%h v=%b flags=%b, want h=%h v=%b flags=%b", et, obs[47:8], obs[7:4], obs[3:0], ev_v[47:8], ev_v[7:4], ev_v[3:0]); end
        end
    endtask

    task automatic test_back_to_back();
        do_restart();
        beat_cnt = 7'd8; tick();          // A = 120
        tick_n(39);                       // A = 159
        beat_cnt = 7'd9; tick();          // A = 160, B = 120
        tick_n(520);                      // A = 680, B = 640
        hit_req = 1'b1;
        beat_cnt = 7'd10;
        push("hit_largest_spawn_slot2", ev(B, S, 641, B, 4'b0110, 4'b1000));
        push("hit_second_block", ev(B, 121, B, B, 4'b0100, 4'b1000));
        push("hit_third_bad", ev(B, 122, B, B, 4'b0100, 4'b0100));
        for (int k = 0; k < 3; k++) begin
            tick();
            et = tag_q.pop_front(); ev_v = val_q.pop_front(); vectors++;
            if (obs !== ev_v) begin miscompares++; $display("FAIL %s: got h=%h v=%b flags=%b, want h=%h v=%b flags=%b", et, obs[47:8], obs[7:4], obs[3:0], ev_v[47:8], ev_v[7:4], ev_v[3:0]); end
        end
        hit_req = 1'b0;
    endtask

    task automatic test_overflow();
        do_restart();
        for (int b = 8; b < 11; b++) begin
            beat_cnt = 7'(b); tick(); tick_n(9);
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin beat_cnt = 7'd11; push("four_slots_full", ev(120, 130, 140, 150, 4'b1111, 4'b0000)); tick(); end
            else if (k == 1) begin tick_n(9); beat_cnt = 7'd12; push("fifth_dropped", ev(130, 140, 150, 160, 4'b1111, 4'b0001)); tick(); end
            else begin tick_n(4); push("overflow_sticky", ev(135, 145, 155, 165, 4'b1111, 4'b0001)); tick(); end
            et = tag_q.pop_front(); ev_v = val_q.pop_front(); vectors++;
            if (obs !== ev_v) begin miscompares++; $display("FAIL %s: got h=%h v=%b flags=%b, want h=%h v=%b flags=%b", et, obs[47:8], obs[7:4], obs[3:0], ev_v[47:8], ev_v[7:4], ev_v[3:0]); end
        end
    endtask

    task automatic test_restart();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                restart = 1'b1; beat_cnt = 7'd0;
                push("restart_clears", ev(B, B, B, B, 4'b0000, 4'b0000));
                tick(); restart = 1'b0;
            end else if (k == 1) begin
                beat_cnt = 7'd8; push("spawn_after_restart", ev(B, B, B, S, 4'b0001, 4'b0000)); tick();
            end else if (k == 2) begin
                tick_n(5);
                rst_n = 1'b0; beat_cnt = 7'd0;
                push("async_reset_mid_fall", ev(B, B, B, B, 4'b0000, 4'b0000));
                #2;
            end else begin
                tick(); rst_n = 1'b1;
                beat_cnt = 7'd8; push("spawn_after_rst", ev(B, B, B, S, 4'b0001, 4'b0000)); tick();
            end
            et = tag_q.pop_front(); ev_v = val_q.pop_front(); vectors++;
            if (obs !== ev_v) begin miscompares++; $display("FAIL %s: got h=%h v=%b flags=%b, want h=%h v=%b flags=%b", et, obs[47:8], obs[7:4], obs[3:0], ev_v[47:8], ev_v[7:4], ev_v[3:0]); end
        end
    endtask

    task automatic test_stop();
        do_restart();
        beat_cnt = 7'd8; tick();          // h0 = 120
        tick_n(10);                       // h0 = 130
        stop_or_endgame = 1'b1;
        tick_n(19);
        beat_cnt = 7'd9;
        tick_n(10);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin hit_req = 1'b1; push("stop_ignores_hit", ev(B, B, B, 130, 4'b0001, 4'b0000)); tick(); hit_req = 1'b0; end
            else if (k == 1) begin tick_n(19); push("stop_holds_50", ev(B, B, B, 130, 4'b0001, 4'b0000)); tick(); end
            else begin stop_or_endgame = 1'b0; push("resume_no_late_spawn", ev(B, B, B, 131, 4'b0001, 4'b0000)); tick(); end
            et = tag_q.pop_front(); ev_v = val_q.pop_front(); vectors++;
            if (obs !== ev_v) begin miscompares++; $display("FAIL %s: got h=%h v=%b flags=%b, want h=%h v=%b flags=%b", et, obs[47:8], obs[7:4], obs[3:0], ev_v[47:8], ev_v[7:4], ev_v[3:0]); end
        end
    endtask

    task automatic test_wrap();
        do_restart();
        beat_cnt = 7'd20; tick();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin beat_cnt = 7'd9; push("wrap_not_new_beat", ev(B, B, B, B, 4'b0000, 4'b0000)); end
            else begin beat_cnt = 7'd10; push("spawn_after_wrap", ev(B, B, B, S, 4'b0001, 4'b0000)); end
            tick();
            et = tag_q.pop_front(); ev_v = val_q.pop_front(); vectors++;
            if (obs !== ev_v) begin miscompares++; $display("FAIL %s: got h=%h v=%b flags=%b, want h=%h v=%b flags=%b", et, obs[47:8], obs[7:4], obs[3:0], ev_v[47:8], ev_v[7:4], ev_v[3:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_hit();
        test_select_and_miss();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_stop();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
